nes_palette_ram_writer: RTL and testbench

//  Writable NES palette memory: CPU-side writer for the 32-entry palette read by the renderer.

---
 rtl/nes_ppu_pkg.sv | 22 ++
 rtl/nes_palette_ram_writer_if.sv | 35 +++
 rtl/nes_palette_ram.sv | 44 ++++
 rtl/nes_palette_ram_writer.sv | 126 ++++++++++++
 tb/tb_nes_palette_ram_writer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/nes_ppu_pkg.sv
// Shared PPU register decode constants and palette mirroring helper.
// Used by the palette writer and its palette RAM.
package nes_ppu_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_ADDR   = 3'd6;
  localparam logic [2:0] REG_DATA   = 3'd7;

  localparam logic [5:0] PAL_PAGE   = 6'h3F;

  // Backdrop entries of the sprite palettes alias the BG ones.
  function automatic logic [4:0] pal_mirror(input logic [4:0] a);
    logic [4:0] m;
    m = a;
    if (a[4] && (a[1:0] == 2'b00)) begin
      m[4] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/nes_palette_ram_writer_if.sv
// CPU register bus into the palette writer plus its VRAM write port.
// master = CPU/system side, slave = palette writer.
interface nes_palette_ram_writer_if #(
  parameter int AW = 14
);

  logic          cpu_we;
  logic          cpu_re;
  logic [2:0]    cpu_reg;
  logic [7:0]    cpu_din;
  logic          vram_we;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_data;

  modport master (
    output cpu_we,
    output cpu_re,
    output cpu_reg,
    output cpu_din,
    input  vram_we,
    input  vram_addr,
    input  vram_data
  );

  modport slave (
    input  cpu_we,
    input  cpu_re,
    input  cpu_reg,
    input  cpu_din,
    output vram_we,
    output vram_addr,
    output vram_data
  );

endinterface

// File: rtl/nes_palette_ram.sv
// 32x6 palette array: one write port, one registered read port.
// Reads return the pre-write value when colliding with a write.
import nes_ppu_pkg::*;

module nes_palette_ram #(
  parameter logic [5:0] RST_VAL = 6'h0F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [5:0] wdata,
  input  logic [4:0] raddr,
  output logic [7:0] dout
);

  logic [5:0] mem_q [32];
  logic [5:0] mem_d [32];
  logic [7:0] dout_q;
  logic [7:0] dout_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
    dout_d = {2'b00, mem_q[pal_mirror(raddr)]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= RST_VAL;
      end
      dout_q <= 8'h00;
    end else begin
      mem_q  <= mem_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/nes_palette_ram_writer.sv
// CPU-side PPU register decoder: PPUADDR toggle, VRAM address counter,
// palette writes with mirroring and forwarding of other PPUDATA writes.
import nes_ppu_pkg::*;

module nes_palette_ram_writer #(
  parameter logic [5:0] PAL_RST_VAL = 6'h0F,
  parameter int         AW          = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nes_palette_ram_writer_if.slave bus,
  input  logic [4:0]             rd_addr,
  output logic [7:0]             dout,
  output logic [AW-1:0]          vaddr
);

  localparam logic [0:0] W_HI = 1'b0;
  localparam logic [0:0] W_LO = 1'b1;

  logic [0:0]    w_q, w_d;
  logic [5:0]    hi_q, hi_d;
  logic          inc32_q, inc32_d;
  logic [AW-1:0] vaddr_q, vaddr_d;
  logic          vram_we_q, vram_we_d;
  logic [AW-1:0] vram_addr_q, vram_addr_d;
  logic [7:0]    vram_data_q, vram_data_d;

  logic          wr_ctrl;
  logic          wr_addr;
  logic          wr_data;
  logic          rd_status;
  logic          is_pal;
  logic          pal_we;
  logic [4:0]    pal_waddr;
  logic [5:0]    pal_wdata;
  logic [AW-1:0] step;

  assign wr_ctrl   = bus.cpu_we && (bus.cpu_reg == REG_CTRL);
  assign wr_addr   = bus.cpu_we && (bus.cpu_reg == REG_ADDR);
  assign wr_data   = bus.cpu_we && (bus.cpu_reg == REG_DATA);
  assign rd_status = bus.cpu_re && (bus.cpu_reg == REG_STATUS);
  assign is_pal    = vaddr_q[AW-1:AW-6] == PAL_PAGE;
  assign step      = inc32_q ? AW'(32) : AW'(1);

  always_comb begin
    w_d         = w_q;
    hi_d        = hi_q;
    inc32_d     = inc32_q;
    vaddr_d     = vaddr_q;
    vram_we_d   = 1'b0;
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    pal_we      = 1'b0;
    pal_waddr   = pal_mirror(vaddr_q[4:0]);
    pal_wdata   = bus.cpu_din[5:0];

    unique case (1'b1)
      wr_ctrl: begin
        inc32_d = bus.cpu_din[2];
      end
      wr_addr: begin
        if (w_q == W_HI) begin
          hi_d = bus.cpu_din[5:0];
          w_d  = W_LO;
        end else begin
          vaddr_d = AW'({hi_q, bus.cpu_din});
          w_d     = W_HI;
        end
      end
      wr_data: begin
        if (is_pal) begin
          pal_we = 1'b1;
        end else begin
          vram_we_d   = 1'b1;
          vram_addr_d = vaddr_q;
          vram_data_d = bus.cpu_din;
        end
        vaddr_d = vaddr_q + step;
      end
      default: ;
    endcase

    // A status read wins over a same-cycle PPUADDR write.
    if (rd_status) begin
      w_d = W_HI;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q         <= W_HI;
      hi_q        <= 6'h00;
      inc32_q     <= 1'b0;
      vaddr_q     <= '0;
      vram_we_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= 8'h00;
    end else begin
      w_q         <= w_d;
      hi_q        <= hi_d;
      inc32_q     <= inc32_d;
      vaddr_q     <= vaddr_d;
      vram_we_q   <= vram_we_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
    end
  end

  nes_palette_ram #(
    .RST_VAL (PAL_RST_VAL)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (pal_we),
    .waddr (pal_waddr),
    .wdata (pal_wdata),
    .raddr (rd_addr),
    .dout  (dout)
  );

  assign vaddr         = vaddr_q;
  assign bus.vram_we   = vram_we_q;
  assign bus.vram_addr = vram_addr_q;
  assign bus.vram_data = vram_data_q;

endmodule

// File: tb/tb_nes_palette_ram_writer.sv
// Bench for nes_palette_ram_writer: directed register sequences plus
// random strobes, all checked against a behavioural PPU model.
module tb_nes_palette_ram_writer;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd_addr;
  logic [7:0]  dout;
  logic [13:0] vaddr;

  nes_palette_ram_writer_if #(.AW(14)) bus ();

  nes_palette_ram_writer #(
    .PAL_RST_VAL (6'h0F),
    .AW          (14)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .rd_addr (rd_addr),
    .dout    (dout),
    .vaddr   (vaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int pal [32];
  int m_vaddr, m_w, m_hi, m_inc32;
  int m_va, m_vd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mir(input int a);
    return (a >= 16 && a % 4 == 0) ? a - 16 : a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pal[i] = 'h0F;
    m_vaddr = 0;
    m_w     = 0;
    m_hi    = 0;
    m_inc32 = 0;
    m_va    = 0;
    m_vd    = 0;
  endtask

  task automatic step(input bit we, input bit re, input int r,
                      input int d, input int ra);
    int ed;
    bit evwe;
    bus.cpu_we  = we;
    bus.cpu_re  = re;
    bus.cpu_reg = r[2:0];
    bus.cpu_din = d[7:0];
    rd_addr     = ra[4:0];
    ed   = pal[mir(ra)];
    evwe = 0;
    if (we) begin
      case (r)
        0: m_inc32 = (d >> 2) & 1;
        6: begin
          if (m_w == 0) begin
            m_hi = d % 64;
            m_w  = 1;
          end else begin
            m_vaddr = m_hi * 256 + d;
            m_w     = 0;
          end
        end
        7: begin
          if (m_vaddr / 256 == 'h3F) begin
            pal[mir(m_vaddr % 32)] = d % 64;
          end else begin
            evwe = 1;
            m_va = m_vaddr;
            m_vd = d;
          end
          m_vaddr = (m_vaddr + (m_inc32 ? 32 : 1)) % 16384;
        end
        default: ;
      endcase
    end
    if (re && r == 2) m_w = 0;
    @(posedge clk);
    #1;
    chk("dout", dout, ed);
    chk("vaddr", vaddr, m_vaddr);
    chk("vram_we", bus.vram_we, evwe);
    if (evwe) begin
      chk("vram_addr", bus.vram_addr, m_va);
      chk("vram_data", bus.vram_data, m_vd);
    end
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
  endtask

  task automatic wr(input int r, input int d);
    step(1'b1, 1'b0, r, d, 0);
  endtask

  task automatic rdp(input int a);
    step(1'b0, 1'b0, 0, 0, a);
  endtask

  task automatic do_reset();
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_dout", dout, 8'h00);
    chk("rst_vaddr", vaddr, 14'h0000);
    chk("rst_vram_we", bus.vram_we, 1'b0);
    chk("rst_vram_addr", bus.vram_addr, 14'h0000);
    chk("rst_vram_data", bus.vram_data, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int r, d;
    bit we, re;
    bus.cpu_we  = 1'b0;
    bus.cpu_re  = 1'b0;
    bus.cpu_reg = 3'd0;
    bus.cpu_din = 8'h00;
    rd_addr     = 5'd0;
    rst_n       = 1'b0;
    model_reset();
    #3;
    do_reset();

    for (int i = 0; i < 32; i++) begin
      rdp(i);
      chk("rst_entry", dout, 8'h0F);
    end

    wr(6, 'h3F); wr(6, 'h01); wr(7, 'h2D); wr(7, 'h27);
    chk("t2_vaddr", vaddr, 14'h3F03);
    rdp(1); chk("t2_e1", dout, 8'h2D);
    rdp(2); chk("t2_e2", dout, 8'h27);

    wr(6, 'h3F); wr(6, 'h10); wr(7, 'h15);
    rdp(0);    chk("t3_e0", dout, 8'h15);
    rdp('h10); chk("t3_e16", dout, 8'h15);
    wr(7, 'h1C);
    rdp('h11); chk("t3_e17", dout, 8'h1C);
    rdp(1);    chk("t3_e1", dout, 8'h2D);

    wr(0, 'h04); wr(6, 'h20); wr(6, 'h00);
    wr(7, 'hAA);
    chk("t4_vwe", bus.vram_we, 1'b1);
    chk("t4_vaddr_o", bus.vram_addr, 14'h2000);
    chk("t4_vdata", bus.vram_data, 8'hAA);
    chk("t4_vaddr", vaddr, 14'h2020);
    rdp(0);
    chk("t4_pulse", bus.vram_we, 1'b0);

    wr(0, 'h00);
    wr(6, 'h3F);
    step(1'b0, 1'b1, 2, 0, 0);
    wr(6, 'h3F); wr(6, 'h1F);
    chk("t5_vaddr", vaddr, 14'h3F1F);
    wr(7, 'h3C); wr(7, 'h00);
    rdp('h1F); chk("t5_e31", dout, 8'h3C);
    wr(6, 'h3F); wr(6, 'hFF); wr(7, 'h11);
    chk("t5_wrap", vaddr, 14'h0000);

    // Same-cycle write and read of entry 3.
    wr(6, 'h3F); wr(6, 'h03);
    step(1'b1, 1'b0, 7, 'h30, 3);
    chk("t6_old", dout, 8'h0F);
    rdp(3);
    chk("t6_new", dout, 8'h30);

    wr(6, 'h3F);
    do_reset();
    wr(6, 'h21); wr(6, 'h05);
    chk("t6_rst_w", vaddr, 14'h2105);

    for (int i = 0; i < 2000; i++) begin
      case ($urandom % 8)
        0: r = 0;
        1: r = 2;
        2, 3: r = 6;
        4, 5, 6: r = 7;
        default: r = 1 + 2 * ($urandom % 3);
      endcase
      we = ($urandom % 4) != 0;
      re = ($urandom % 6) == 0;
      d  = (r == 6 && ($urandom % 2) == 1) ? 'h3F : int'($urandom % 256);
      step(we, re, r, d, int'($urandom % 32));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
